// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter and the tri-state bus it drives.
package bus_pkg;

    // Arbiter FSM states; explicit 2-bit encoding kept stable for legacy tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Defaults shared with the bus instance so select widths always match.
    localparam int DEF_NUM_SRC  = 32;
    localparam int DEF_MAX_HOLD = 16;

    // Grant index width; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit at or above 'start', with wrap-around.
module rr_pick
    import bus_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    localparam int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_SRC-1:0] onehot
);

    localparam logic [IDX_W:0] NUM_EXT = (IDX_W + 1)'(NUM_SRC);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic [IDX_W:0]       wrapped;

    // Rotating a doubled copy puts the search start at bit 0.
    assign dbl = {req, req};
    assign rot = NUM_SRC'(dbl >> start);

    // Priority encode: lowest set bit of the rotated vector wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
    end

    // Undo the rotation modulo NUM_SRC.
    assign sum     = {1'b0, start} + {1'b0, off};
    assign wrapped = sum - NUM_EXT;
    assign winner  = (sum >= NUM_EXT) ? wrapped[IDX_W-1:0] : sum[IDX_W-1:0];
    assign onehot  = found ? (NUM_SRC'(1) << winner) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with lockable, hold-bounded grants and a one-cycle
// turnaround between owners. All outputs come straight from flops.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int NUM_SRC  = DEF_NUM_SRC,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IDX_W    = idx_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] lock,
    output logic [NUM_SRC-1:0] sel_lines,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout
);

    localparam int              HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SRC - 1);

    arb_state_t         state_reg,   state_next;
    logic [HOLD_W-1:0]  hold_reg,    hold_next;
    logic [IDX_W-1:0]   ptr_reg,     ptr_next;
    logic [NUM_SRC-1:0] sel_reg,     sel_next;
    logic [IDX_W-1:0]   idx_reg,     idx_next;
    logic               valid_reg,   valid_next;
    logic               timeout_reg, timeout_next;

    logic [IDX_W-1:0]   start;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_SRC-1:0] pick_onehot;
    logic               owner_locked;

    // Search begins just past the last owner.
    assign start = (ptr_reg == LAST_IDX) ? '0 : ptr_reg + 1'b1;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req    (req),
        .start  (start),
        .found  (pick_found),
        .winner (pick_idx),
        .onehot (pick_onehot)
    );

    assign owner_locked = req[idx_reg] & lock[idx_reg];

    // Next-state logic: arbitrate in IDLE, extend or release in GRANT, gap in TURN.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        ptr_next     = ptr_reg;
        sel_next     = sel_reg;
        idx_next     = idx_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    sel_next   = pick_onehot;
                    idx_next   = pick_idx;
                    valid_next = 1'b1;
                    ptr_next   = pick_idx;
                    hold_next  = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (owner_locked && (hold_reg < HOLD_LAST)) begin
                    hold_next = hold_reg + 1'b1;
                end else begin
                    // A still-locked owner reaching here has hit the hold limit.
                    timeout_next = owner_locked;
                    sel_next     = '0;
                    idx_next     = '0;
                    valid_next   = 1'b0;
                    hold_next    = '0;
                    state_next   = TURN;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                sel_next   = '0;
                idx_next   = '0;
                valid_next = 1'b0;
                hold_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus selects at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            ptr_reg     <= LAST_IDX;
            sel_reg     <= '0;
            idx_reg     <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            ptr_reg     <= ptr_next;
            sel_reg     <= sel_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    assign sel_lines   = sel_reg;
    assign grant_valid = valid_reg;
    assign grant_idx   = idx_reg;
    assign timeout     = timeout_reg;

    a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(sel_lines));
    a_valid:  assert property (@(posedge clk) disable iff (!reset_n) grant_valid == (|sel_lines));
    a_to_now: assert property (@(posedge clk) disable iff (!reset_n) timeout |-> (sel_lines == '0));
    a_to_nxt: assert property (@(posedge clk) disable iff (!reset_n) timeout |=> (sel_lines == '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand sequences for async reset
// and 32-source wrap, then random traffic against a cycle-level owner model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic [N-1:0] sel_lines;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timeout;

    logic [31:0]  req32 = '0;
    logic [31:0]  lock32 = '0;
    logic [31:0]  sel32;
    logic         valid32;
    logic [4:0]   idx32;
    logic         to32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_SRC(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
        .sel_lines(sel_lines), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .timeout(timeout)
    );

    bus_arbiter #(.NUM_SRC(32), .MAX_HOLD(16)) dut32 (
        .clk(clk), .reset_n(reset_n), .req(req32), .lock(lock32),
        .sel_lines(sel32), .grant_valid(valid32),
        .grant_idx(idx32), .timeout(to32)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] sel;
        int           idx;
        logic         to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [N-1:0] r, input logic [N-1:0] l,
                                input logic [N-1:0] s, input int idx, input logic to);
        vec_t v;
        v.req = r; v.lock = l; v.sel = s; v.idx = idx; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [N-1:0] s, input int idx, input logic to);
        checks++;
        if (sel_lines !== s || grant_valid !== (s != 0) || grant_idx !== 2'(idx) || timeout !== to) begin
            failures++;
            $display("FAIL %s: got sel=%b valid=%b idx=%0d to=%b, want sel=%b valid=%b idx=%0d to=%b",
                     name, sel_lines, grant_valid, grant_idx, timeout, s, (s != 0), idx, to);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] s, input int idx);
        checks++;
        if (sel32 !== s || valid32 !== (s != 0) || idx32 !== 5'(idx) || to32 !== 1'b0) begin
            failures++;
            $display("FAIL %s: got sel=%h idx=%0d to=%b, want sel=%h idx=%0d to=0",
                     name, sel32, idx32, to32, s, idx);
        end
    endtask

    // Reference model: who owns the bus, for how many cycles, and whether
    // the mandatory one-cycle gap after a release is still pending.
    int   m_owner;
    int   m_held;
    int   m_last;
    bit   m_gap;
    logic m_to;

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_last = N - 1; m_gap = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (r[m_owner] && l[m_owner] && m_held < MH) begin
                m_held++;
            end else begin
                m_to    = r[m_owner] && l[m_owner];
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (r[c]) begin
                    m_owner = c; m_last = c; m_held = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0; lock = '0; req32 = '0; lock32 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] m_sel;

        // ---- directed table ----
        for (int i = 0; i < 10; i++) add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0100, 2, 1'b0);
        add(4'b0100, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0100, 2, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        // all requesting, rotating from last owner 2
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (3 + k) % N;
            add(4'b1111, 4'b0000, 4'(1 << g), g, 1'b0);
            add(4'b1111, 4'b0000, 4'b0000, 0, 1'b0);
            add(4'b1111, 4'b0000, 4'b0000, 0, 1'b0);
        end
        add(4'b1111, 4'b0000, 4'b1000, 3, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        // locked to the hold limit
        for (int i = 0; i < 4; i++) add(4'b0010, 4'b0010, 4'b0010, 1, 1'b0);
        add(4'b0010, 4'b0010, 4'b0000, 0, 1'b1);
        add(4'b0010, 4'b0010, 4'b0000, 0, 1'b0);
        add(4'b0010, 4'b0010, 4'b0010, 1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        // short lock then release, next source after the gap
        add(4'b0011, 4'b0001, 4'b0001, 0, 1'b0);
        add(4'b0011, 4'b0001, 4'b0001, 0, 1'b0);
        add(4'b0011, 4'b0001, 4'b0001, 0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        // lock from a non-owner is ignored
        add(4'b0010, 4'b0001, 4'b0010, 1, 1'b0);
        add(4'b0010, 4'b0001, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0001, 4'b0000, 0, 1'b0);
        // owner drops req while locked
        add(4'b0100, 4'b0100, 4'b0100, 2, 1'b0);
        add(4'b0000, 4'b0100, 4'b0000, 0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 1'b0);

        do_reset();
        check("reset", 4'b0000, 0, 1'b0);

        foreach (vecs[i]) begin
            req = vecs[i].req; lock = vecs[i].lock;
            @(posedge clk); #1;
            $display("vec %0d req=%b lock=%b sel=%b idx=%0d to=%b", i, req, lock, sel_lines, grant_idx, timeout);
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].idx, vecs[i].to);
        end

        // ---- async reset mid-grant ----
        req = 4'b1000; lock = 4'b1000;
        @(posedge clk); #1;
        check("grant3", 4'b1000, 3, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        req = 4'b1001; lock = 4'b0000;
        @(posedge clk); #1;
        check("post_reset_src0", 4'b0001, 0, 1'b0);
        req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // ---- 32-source wrap ----
        req32 = 32'h8000_0000;
        @(posedge clk); #1;
        check32("w32_own31", 32'h8000_0000, 31);
        req32 = 32'h8000_0001;
        @(posedge clk); #1;
        check32("w32_turn", 32'h0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("w32_wrap0", 32'h0000_0001, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("w32_then31", 32'h8000_0000, 31);
        req32 = '0;

        // ---- random traffic vs model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req  = req ^ 4'($urandom & $urandom);
            lock = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom);
            @(posedge clk);
            model_step(req, lock);
            #1;
            m_sel = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            $display("rnd %0d req=%b lock=%b sel=%b to=%b", cyc, req, lock, sel_lines, timeout);
            check($sformatf("rnd%0d", cyc), m_sel, (m_owner >= 0) ? m_owner : 0, m_to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
